// File: rtl/ins_fetch_seq_if.sv
// Bus between the fetch/sequencing stage and the multicycle decoder.
// The master (decoder side) drives the controls and the fetch stage returns PC, IR and step state.
interface ins_fetch_seq_if #(
  parameter int unsigned PC_W = 16
);
  logic [15:0]     MemIns;
  logic [PC_W-1:0] RegTarget;
  logic            Buff_MEMIns;
  logic            Buff_PC;
  logic            Branch;
  logic [1:0]      Jump;
  logic            Done;

  logic [PC_W-1:0] PC;
  logic [PC_W-1:0] PCplus1;
  logic [15:0]     IR;
  logic [7:0]      InsM;
  logic [1:0]      InsL;
  logic [2:0]      Cnt;
  logic            Halted;
  logic            StepErr;

  modport master (
    output MemIns, RegTarget, Buff_MEMIns, Buff_PC, Branch, Jump, Done,
    input  PC, PCplus1, IR, InsM, InsL, Cnt, Halted, StepErr
  );

  modport slave (
    input  MemIns, RegTarget, Buff_MEMIns, Buff_PC, Branch, Jump, Done,
    output PC, PCplus1, IR, InsM, InsL, Cnt, Halted, StepErr
  );
endinterface

// File: rtl/ins_fetch_seq.sv
// Fetch/sequencing stage: owns PC, IR and the step counter, advancing them
// under the decoder's Buff_PC/Buff_MEMIns/Branch/Jump/Done controls.
module ins_fetch_seq #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [2:0]      MAX_CNT  = 3'd7
) (
  input  logic            clk,
  input  logic            Rst,
  ins_fetch_seq_if.slave  bus
);

  localparam int unsigned BR_W  = 8;
  localparam int unsigned JMP_W = 11;

  localparam logic [1:0] JUMP_SEQ = 2'b00;
  localparam logic [1:0] JUMP_REG = 2'b01;
  localparam logic [1:0] JUMP_REL = 2'b10;

  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [2:0]      cnt_q;
  logic            halted_q;
  logic            step_err_q;

  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] jmp_off;
  logic [PC_W-1:0] next_pc;

  // Sign-extended IR offsets; arithmetic wraps modulo 2^PC_W.
  assign pc_plus1 = pc_q + PC_W'(1);
  assign br_off   = {{(PC_W - BR_W){ir_q[BR_W-1]}}, ir_q[BR_W-1:0]};
  assign jmp_off  = {{(PC_W - JMP_W){ir_q[JMP_W-1]}}, ir_q[JMP_W-1:0]};

  // Next-PC select; Branch only matters for the sequential source, and 2'b11 falls through to PC+1.
  always_comb begin
    next_pc = pc_plus1;
    case (bus.Jump)
      JUMP_SEQ: if (bus.Branch) next_pc = pc_plus1 + br_off;
      JUMP_REG: next_pc = bus.RegTarget;
      JUMP_REL: next_pc = pc_plus1 + jmp_off;
      default:  next_pc = pc_plus1;
    endcase
  end

  // Once halted, only reset can move any state.
  always_ff @(posedge clk) begin
    if (Rst) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      cnt_q      <= '0;
      halted_q   <= 1'b0;
      step_err_q <= 1'b0;
    end else if (!halted_q) begin
      if (bus.Buff_MEMIns) ir_q <= bus.MemIns;
      if (bus.Buff_PC) begin
        pc_q  <= next_pc;
        cnt_q <= '0;
      end else if (cnt_q == MAX_CNT) begin
        // Ran out of steps without a PC load: restart the count, flag it, leave PC alone.
        cnt_q      <= '0;
        step_err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
      if (bus.Done) halted_q <= 1'b1;
    end
  end

  assign bus.PC      = pc_q;
  assign bus.PCplus1 = pc_plus1;
  assign bus.IR      = ir_q;
  assign bus.InsM    = ir_q[15:8];
  assign bus.InsL    = ir_q[1:0];
  assign bus.Cnt     = cnt_q;
  assign bus.Halted  = halted_q;
  assign bus.StepErr = step_err_q;

endmodule

// File: tb/tb_ins_fetch_seq.sv
// Directed bench for ins_fetch_seq: stimulus pushes expected state into a queue,
// a monitor pops and compares on the falling edge after each driven cycle.
module tb_ins_fetch_seq;

  logic clk;
  logic Rst;

  ins_fetch_seq_if #(.PC_W(16)) bus ();

  ins_fetch_seq #(
    .PC_W    (16),
    .RESET_PC(16'h0000),
    .MAX_CNT (3'd7)
  ) dut (
    .clk(clk),
    .Rst(Rst),
    .bus(bus)
  );

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [2:0]  cnt;
    logic        halted;
    logic        step_err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic rst, input logic bmem, input logic bpc, input logic br,
                     input logic [1:0] jmp, input logic dn,
                     input logic [15:0] mi, input logic [15:0] rt);
    Rst             = rst;
    bus.Buff_MEMIns = bmem;
    bus.Buff_PC     = bpc;
    bus.Branch      = br;
    bus.Jump        = jmp;
    bus.Done        = dn;
    bus.MemIns      = mi;
    bus.RegTarget   = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string name, input logic [15:0] pc, input logic [15:0] ir,
                           input logic [2:0] cnt, input logic h, input logic e);
    exp_t x;
    x.name = name; x.pc = pc; x.ir = ir; x.cnt = cnt; x.halted = h; x.step_err = e;
    exp_q.push_back(x);
  endtask

  // Monitor: compare every pending expectation against the registered outputs.
  initial begin
    exp_t x;
    logic [15:0] pc1;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        x   = exp_q.pop_front();
        pc1 = x.pc + 16'd1;
        checks++;
        if (bus.PC !== x.pc || bus.PCplus1 !== pc1 || bus.IR !== x.ir ||
            bus.InsM !== x.ir[15:8] || bus.InsL !== x.ir[1:0] || bus.Cnt !== x.cnt ||
            bus.Halted !== x.halted || bus.StepErr !== x.step_err) begin
          errors++;
          $display("FAIL %s: got PC=%h PCplus1=%h IR=%h InsM=%h InsL=%h Cnt=%0d H=%b E=%b, want PC=%h PCplus1=%h IR=%h InsM=%h InsL=%h Cnt=%0d H=%b E=%b",
                   x.name, bus.PC, bus.PCplus1, bus.IR, bus.InsM, bus.InsL, bus.Cnt,
                   bus.Halted, bus.StepErr, x.pc, pc1, x.ir, x.ir[15:8], x.ir[1:0],
                   x.cnt, x.halted, x.step_err);
        end
      end
    end
  end

  initial begin
    // Reset then a plain sequential instruction
    cyc(1, 0, 0, 0, 2'b00, 0, 16'h0800, 16'h0000); expect_st("reset1", 16'h0000, 16'h0000, 3'd0, 0, 0);
    cyc(1, 0, 0, 0, 2'b00, 0, 16'h0800, 16'h0000); expect_st("reset2", 16'h0000, 16'h0000, 3'd0, 0, 0);
    cyc(0, 1, 0, 0, 2'b00, 0, 16'h0800, 16'h0000); expect_st("fetch",  16'h0000, 16'h0800, 3'd1, 0, 0);
    cyc(0, 0, 0, 0, 2'b00, 0, 16'h0800, 16'h0000); expect_st("step2",  16'h0000, 16'h0800, 3'd2, 0, 0);
    cyc(0, 0, 1, 0, 2'b00, 0, 16'h0800, 16'h0000); expect_st("seq_pc", 16'h0001, 16'h0800, 3'd0, 0, 0);

    // Branches
    cyc(0, 1, 1, 0, 2'b01, 0, 16'hC0FE, 16'h0010); expect_st("jr_setup", 16'h0010, 16'hC0FE, 3'd0, 0, 0);
    cyc(0, 0, 1, 1, 2'b00, 0, 16'h0000, 16'h0000); expect_st("br_taken", 16'h000F, 16'hC0FE, 3'd0, 0, 0);
    cyc(0, 0, 1, 0, 2'b01, 0, 16'h0000, 16'h0010); expect_st("jr_again", 16'h0010, 16'hC0FE, 3'd0, 0, 0);
    cyc(0, 0, 1, 0, 2'b00, 0, 16'h0000, 16'h0000); expect_st("br_not",   16'h0011, 16'hC0FE, 3'd0, 0, 0);

    // Jumps
    cyc(0, 0, 1, 1, 2'b01, 0, 16'h0000, 16'h1234); expect_st("jr_1234",   16'h1234, 16'hC0FE, 3'd0, 0, 0);
    cyc(0, 1, 1, 0, 2'b01, 0, 16'h07FF, 16'h0005); expect_st("setup_rel", 16'h0005, 16'h07FF, 3'd0, 0, 0);
    cyc(0, 0, 1, 1, 2'b10, 0, 16'h0000, 16'h0000); expect_st("j_rel",     16'h0005, 16'h07FF, 3'd0, 0, 0);
    cyc(0, 0, 1, 0, 2'b11, 0, 16'h0000, 16'h9999); expect_st("j_rsv",     16'h0006, 16'h07FF, 3'd0, 0, 0);
    cyc(0, 0, 1, 0, 2'b01, 0, 16'h0000, 16'hFFFF); expect_st("setup_wrap",16'hFFFF, 16'h07FF, 3'd0, 0, 0);
    cyc(0, 0, 1, 0, 2'b00, 0, 16'h0000, 16'h0000); expect_st("wrap",      16'h0000, 16'h07FF, 3'd0, 0, 0);

    // Watchdog: eight cycles without a PC load
    for (int i = 1; i <= 7; i++) begin
      cyc(0, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000);
      expect_st($sformatf("wd_cnt%0d", i), 16'h0000, 16'h07FF, 3'(i), 0, 0);
    end
    cyc(0, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000); expect_st("wd_trip",   16'h0000, 16'h07FF, 3'd0, 0, 1);
    cyc(0, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000); expect_st("wd_sticky", 16'h0000, 16'h07FF, 3'd1, 0, 1);
    cyc(0, 0, 1, 0, 2'b00, 0, 16'h0000, 16'h0000); expect_st("wd_resume", 16'h0001, 16'h07FF, 3'd0, 0, 1);

    // Halt together with a PC load, then frozen
    cyc(0, 0, 1, 0, 2'b01, 0, 16'h0000, 16'h0003); expect_st("setup_halt", 16'h0003, 16'h07FF, 3'd0, 0, 1);
    cyc(0, 0, 1, 0, 2'b00, 1, 16'h0000, 16'h0000); expect_st("halt",       16'h0004, 16'h07FF, 3'd0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1'(i % 2), 1'((i + 1) % 2), 0, 2'b01, 0, 16'hABCD, 16'h5555);
      expect_st($sformatf("frozen%0d", i), 16'h0004, 16'h07FF, 3'd0, 1, 1);
    end
    cyc(1, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000); expect_st("halt_rst", 16'h0000, 16'h0000, 3'd0, 0, 0);

    // Reset mid-instruction discards a simultaneous PC load
    cyc(0, 1, 0, 0, 2'b00, 0, 16'h1111, 16'h0000); expect_st("mid_fetch", 16'h0000, 16'h1111, 3'd1, 0, 0);
    cyc(0, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000); expect_st("mid_step",  16'h0000, 16'h1111, 3'd2, 0, 0);
    cyc(1, 1, 1, 0, 2'b01, 1, 16'h3333, 16'h2222); expect_st("mid_rst",   16'h0000, 16'h0000, 3'd0, 0, 0);
    cyc(0, 0, 0, 0, 2'b00, 0, 16'h0000, 16'h0000); expect_st("post_rst",  16'h0000, 16'h0000, 3'd1, 0, 0);

    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound in case the clock or stimulus ever stalls.
  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL timeout: stimulus not finished, want finished");
      $fatal(1, "timeout");
    end
  end

endmodule
